qspi_rx_ctrl: RTL and testbench

Sequencer for the Quad-SPI receive path. It accepts a read command from the host side and frames the transfer: chip select, SCK enable, optional dummy cycles, then exactly the nibble count needed for 1–4 bytes. It drives `valid`/`lsb`/`msb` into `qspi_rx_shift`, captures the shifter's 32-bit `data_o`, and returns the word over a valid/ready handshake. It sits between the register/bus front end and `qspi_rx_shift`.

---
 rtl/qspi_rx_ctrl.sv | 176 +++++++++++++++++
 tb/tb_qspi_rx_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rx_ctrl.sv
// Quad-SPI receive sequencer: frames CS/SCK, dummy and nibble phases around
// qspi_rx_shift, then returns the masked read word over a valid/ready handshake.
module qspi_rx_ctrl #(
  parameter int DW      = 32,
  parameter int DUMMY_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         nbytes_i,
  input  logic [DUMMY_W-1:0] dummy_i,
  input  logic               lsb_first_i,
  input  logic               abort_i,
  output logic               cs_no,
  output logic               sck_en_o,
  output logic               shift_valid_o,
  output logic               shift_lsb_o,
  output logic               shift_msb_o,
  input  logic [DW-1:0]      shift_data_i,
  output logic [DW-1:0]      rdata_o,
  output logic               rdata_valid_o,
  input  logic               rdata_ready_i,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    DUMMY  = 3'd2,
    SHIFT  = 3'd3,
    SETTLE = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam int NB = DW / 8;

  state_t             state_q, state_d;
  logic [1:0]         nbytes_q, nbytes_d;
  logic [DUMMY_W-1:0] dummy_q, dummy_d;
  logic               lsb_first_q, lsb_first_d;
  logic [DUMMY_W-1:0] dcnt_q, dcnt_d;
  logic [2:0]         nib_q, nib_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               cs_n_q, cs_n_d;
  logic               sck_en_q, sck_en_d;
  logic               svalid_q, svalid_d;
  logic               slsb_q, slsb_d;
  logic               smsb_q, smsb_d;
  logic [DW-1:0]      byte_mask;

  // Keep only the bytes actually transferred; stale shifter bits above are zeroed.
  for (genvar gi = 0; gi < NB; gi++) begin : g_mask
    assign byte_mask[gi*8 +: 8] = (gi <= int'(nbytes_q)) ? 8'hFF : 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    nbytes_d    = nbytes_q;
    dummy_d     = dummy_q;
    lsb_first_d = lsb_first_q;
    dcnt_d      = dcnt_q;
    nib_d       = nib_q;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          nbytes_d    = nbytes_i;
          dummy_d     = dummy_i;
          lsb_first_d = lsb_first_i;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (dummy_q != '0) begin
          dcnt_d  = dummy_q;
          state_d = DUMMY;
        end else begin
          nib_d   = {nbytes_q, 1'b1};
          state_d = SHIFT;
        end
      end
      DUMMY: begin
        if (abort_i) begin
          dcnt_d  = '0;
          state_d = IDLE;
        end else if (dcnt_q == DUMMY_W'(1)) begin
          dcnt_d  = '0;
          nib_d   = {nbytes_q, 1'b1};
          state_d = SHIFT;
        end else begin
          dcnt_d = dcnt_q - DUMMY_W'(1);
        end
      end
      SHIFT: begin
        if (abort_i) begin
          nib_d   = '0;
          state_d = IDLE;
        end else if (nib_q == 3'd0) begin
          state_d = SETTLE;
        end else begin
          nib_d = nib_q - 3'd1;
        end
      end
      SETTLE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          rdata_d  = shift_data_i & byte_mask;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rdata_ready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are decoded from the next state so they register in step with it.
    cs_n_d   = !(state_d == SETUP || state_d == DUMMY || state_d == SHIFT);
    sck_en_d = (state_d == DUMMY) || (state_d == SHIFT);
    svalid_d = (state_d == SHIFT);
    slsb_d   = svalid_d & lsb_first_d;
    smsb_d   = svalid_d & ~lsb_first_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      nbytes_q    <= '0;
      dummy_q     <= '0;
      lsb_first_q <= 1'b0;
      dcnt_q      <= '0;
      nib_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_en_q    <= 1'b0;
      svalid_q    <= 1'b0;
      slsb_q      <= 1'b0;
      smsb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nbytes_q    <= nbytes_d;
      dummy_q     <= dummy_d;
      lsb_first_q <= lsb_first_d;
      dcnt_q      <= dcnt_d;
      nib_q       <= nib_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      cs_n_q      <= cs_n_d;
      sck_en_q    <= sck_en_d;
      svalid_q    <= svalid_d;
      slsb_q      <= slsb_d;
      smsb_q      <= smsb_d;
    end
  end

  assign cs_no         = cs_n_q;
  assign sck_en_o      = sck_en_q;
  assign shift_valid_o = svalid_q;
  assign shift_lsb_o   = slsb_q;
  assign shift_msb_o   = smsb_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_rx_ctrl.sv
// Directed bench for qspi_rx_ctrl with a small nibble-shifter model on the data side.
module tb_qspi_rx_ctrl;

  localparam int DW      = 32;
  localparam int DUMMY_W = 4;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic [1:0]         nbytes_i;
  logic [DUMMY_W-1:0] dummy_i;
  logic               lsb_first_i;
  logic               abort_i;
  logic               cs_no;
  logic               sck_en_o;
  logic               shift_valid_o;
  logic               shift_lsb_o;
  logic               shift_msb_o;
  logic [DW-1:0]      shift_data_i;
  logic [DW-1:0]      rdata_o;
  logic               rdata_valid_o;
  logic               rdata_ready_i;
  logic               busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qspi_rx_ctrl #(.DW(DW), .DUMMY_W(DUMMY_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .nbytes_i     (nbytes_i),
    .dummy_i      (dummy_i),
    .lsb_first_i  (lsb_first_i),
    .abort_i      (abort_i),
    .cs_no        (cs_no),
    .sck_en_o     (sck_en_o),
    .shift_valid_o(shift_valid_o),
    .shift_lsb_o  (shift_lsb_o),
    .shift_msb_o  (shift_msb_o),
    .shift_data_i (shift_data_i),
    .rdata_o      (rdata_o),
    .rdata_valid_o(rdata_valid_o),
    .rdata_ready_i(rdata_ready_i),
    .busy_o       (busy_o)
  );

  // Shifter model: preloaded with junk so masking is visible; nibbles base, base+1, ...
  logic [31:0] sh_reg;
  logic [2:0]  sh_idx;
  logic [3:0]  nib_cur;
  logic [3:0]  nib_base;
  logic        sh_load;

  always @(posedge clk) begin
    if (sh_load) begin
      sh_reg  <= 32'hDEADBEEF;
      sh_idx  <= 3'd0;
      nib_cur <= nib_base;
    end else if (shift_valid_o) begin
      if (shift_msb_o) sh_reg <= {sh_reg[27:0], nib_cur};
      else             sh_reg[{sh_idx, 2'b00} +: 4] <= nib_cur;
      sh_idx  <= sh_idx + 3'd1;
      nib_cur <= nib_cur + 4'd1;
    end
  end
  assign shift_data_i = sh_reg;

  typedef struct packed {
    logic [1:0]  n;
    logic [3:0]  d;
    logic        lsb;
    logic [3:0]  base;
    logic        ab;
    logic [31:0] exp_data;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one read and watch it cycle by cycle until rdata_valid_o (k = edges since E0).
  task automatic run_xfer(input logic [1:0] n, input logic [3:0] d, input logic lsb,
                          input logic [3:0] base, input logic ab,
                          output int lat, output int first_sh, output int sh_cnt,
                          output int dm_cnt, output int pin_err, output logic cs_pre,
                          output logic cs_pre2, output logic busy0, output logic cs0,
                          output logic [31:0] data);
    logic prev1, prev2;
    int k;
    @(negedge clk);
    nbytes_i = n; dummy_i = d; lsb_first_i = lsb; nib_base = base;
    sh_load = 1'b1; start_i = 1'b1; abort_i = ab;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0; sh_load = 1'b0;
    lat = -1; first_sh = -1; sh_cnt = 0; dm_cnt = 0; pin_err = 0;
    prev1 = 1'bx; prev2 = 1'bx; cs_pre = 1'bx; cs_pre2 = 1'bx; data = 'x;
    busy0 = busy_o; cs0 = cs_no;
    k = 0;
    while (k <= 60 && lat < 0) begin
      if (shift_valid_o) begin
        sh_cnt++;
        if (first_sh < 0) first_sh = k;
        if (shift_lsb_o !== lsb || shift_msb_o !== !lsb) pin_err++;
      end else if (shift_lsb_o || shift_msb_o) begin
        pin_err++;
      end
      if (sck_en_o && !shift_valid_o && !cs_no) dm_cnt++;
      if (rdata_valid_o) begin
        lat = k; cs_pre = prev1; cs_pre2 = prev2; data = rdata_o;
      end else begin
        prev2 = prev1; prev1 = cs_no;
        @(negedge clk);
        k++;
      end
    end
    $display("[TB] xfer n=%0d d=%0d lsb=%0d abort_w_start=%0d lat=%0d rdata=%08h",
             n, d, lsb, ab, lat, data);
  endtask

  int          lat, first_sh, sh_cnt, dm_cnt, pin_err, vcnt;
  logic        cs_pre, cs_pre2, busy0, cs0;
  logic [31:0] data;

  initial begin
    vecs[0] = '{2'd3, 4'd0,  1'b0, 4'h1, 1'b0, 32'h12345678, 8'd10};
    vecs[1] = '{2'd0, 4'd6,  1'b1, 4'hA, 1'b0, 32'h000000BA, 8'd10};
    vecs[2] = '{2'd1, 4'd0,  1'b0, 4'h3, 1'b1, 32'h00003456, 8'd6};
    vecs[3] = '{2'd2, 4'd15, 1'b1, 4'h0, 1'b0, 32'h00543210, 8'd23};
    vecs[4] = '{2'd3, 4'd1,  1'b1, 4'h8, 1'b0, 32'hFEDCBA98, 8'd11};
    vecs[5] = '{2'd0, 4'd0,  1'b0, 4'hC, 1'b0, 32'h000000CD, 8'd4};

    rst_ni = 1'b0; start_i = 1'b0; nbytes_i = '0; dummy_i = '0; lsb_first_i = 1'b0;
    abort_i = 1'b0; rdata_ready_i = 1'b1; sh_load = 1'b0; nib_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {31'd0, cs_no, sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o,
                     rdata_valid_o, busy_o}, 32'h40);
    chk("rst_rdata", rdata_o, 32'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].n, vecs[i].d, vecs[i].lsb, vecs[i].base, vecs[i].ab,
               lat, first_sh, sh_cnt, dm_cnt, pin_err, cs_pre, cs_pre2, busy0, cs0, data);
      chk($sformatf("v%0d_busy_e0", i), {31'd0, busy0}, 32'd1);
      chk($sformatf("v%0d_cs_e0", i), {31'd0, cs0}, 32'd0);
      chk($sformatf("v%0d_lat", i), lat, {24'd0, vecs[i].exp_lat});
      chk($sformatf("v%0d_rdata", i), data, vecs[i].exp_data);
      chk($sformatf("v%0d_shift_cnt", i), sh_cnt, 2 * (int'(vecs[i].n) + 1));
      chk($sformatf("v%0d_dummy_cnt", i), dm_cnt, int'(vecs[i].d));
      chk($sformatf("v%0d_first_shift", i), first_sh, 1 + int'(vecs[i].d));
      chk($sformatf("v%0d_pin_err", i), pin_err, 0);
      chk($sformatf("v%0d_cs_pre1", i), {31'd0, cs_pre}, 32'd1);
      chk($sformatf("v%0d_cs_pre2", i), {31'd0, cs_pre2}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), {30'd0, busy_o, rdata_valid_o}, 32'd0);
    end

    // Backpressure: RESP held, start and abort during RESP ignored.
    rdata_ready_i = 1'b0;
    run_xfer(2'd3, 4'd0, 1'b0, 4'h1, 1'b0,
             lat, first_sh, sh_cnt, dm_cnt, pin_err, cs_pre, cs_pre2, busy0, cs0, data);
    chk("bp_lat", lat, 10);
    chk("bp_rdata", data, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      start_i = (i == 1); abort_i = (i == 2);
      nbytes_i = 2'd0; dummy_i = 4'd0;
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, rdata_valid_o}, 32'd1);
      chk($sformatf("bp_hold_data%0d", i), rdata_o, 32'h12345678);
    end
    start_i = 1'b0; abort_i = 1'b0;
    rdata_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, busy_o, rdata_valid_o}, 32'd0);
    @(negedge clk);
    chk("bp_no_queue", {31'd0, busy_o}, 32'd0);
    $display("[TB] backpressure sequence done rdata=%08h", rdata_o);

    // Abort on the 3rd SHIFT cycle of a 4-byte read.
    @(negedge clk);
    nbytes_i = 2'd3; dummy_i = 4'd0; lsb_first_i = 1'b0; nib_base = 4'h4;
    sh_load = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; sh_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_in_shift", {31'd0, shift_valid_o}, 32'd1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("ab_outs", {28'd0, cs_no, sck_en_o, busy_o, shift_valid_o}, 32'h8);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdata_valid_o) vcnt++;
    end
    chk("ab_no_valid", vcnt, 0);
    chk("ab_rdata_kept", rdata_o, 32'h12345678);
    $display("[TB] abort sequence done rdata=%08h", rdata_o);

    // Reset pulse during DUMMY, then a normal 2-byte read.
    @(negedge clk);
    nbytes_i = 2'd2; dummy_i = 4'd8; lsb_first_i = 1'b0; nib_base = 4'h0;
    sh_load = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; sh_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_in_dummy", {30'd0, sck_en_o, shift_valid_o}, 32'h2);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    chk("rs_outs", {31'd0, cs_no, sck_en_o, shift_valid_o, shift_lsb_o, shift_msb_o,
                    rdata_valid_o, busy_o}, 32'h40);
    chk("rs_rdata", rdata_o, 32'h0);
    run_xfer(2'd1, 4'd0, 1'b0, 4'h5, 1'b0,
             lat, first_sh, sh_cnt, dm_cnt, pin_err, cs_pre, cs_pre2, busy0, cs0, data);
    chk("rs_lat", lat, 6);
    chk("rs_rdata_after", data, 32'h00005678);
    chk("rs_shift_cnt", sh_cnt, 4);
    @(negedge clk);
    chk("rs_idle_after", {30'd0, busy_o, rdata_valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
